// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle iterative shifter (SLL / SRL / SRA) for the
// MIPS datapath. Shifts STEP bits per clock under a start/done handshake,
// giving variable-amount shifts without a full barrel shifter.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start_i   request pulse, sampled only when not busy (IDLE or DONE)
//   op_i      00 SLL, 01 SRL, 10 SRA, 11 treated as SLL
//   data_i    operand, captured on an accepted start
//   shamt_i   shift amount, captured on an accepted start
//   busy_o    high while shifting
//   done_o    one-cycle pulse, result_o valid
//   result_o  shifted result, held until the next operation completes
module seq_shift_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int STEP        = 1     // 1, 2 or 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  result_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Per-cycle shift amount never exceeds STEP (<= 4), so 3 bits suffice.
    localparam int KW = 3;
    localparam logic [SHAMT_WIDTH-1:0] STEP_C = SHAMT_WIDTH'(STEP);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  sreg;
    logic [SHAMT_WIDTH-1:0] count;
    logic [1:0]             op;

    logic                   last;
    logic [KW-1:0]          k;
    logic [DATA_WIDTH-1:0]  shifted;

    // Final step shifts by whatever remains; earlier steps shift by STEP.
    always_comb begin
        last = (count <= STEP_C);
        k    = last ? KW'(count) : KW'(STEP);
        case (op)
            2'b01:   shifted = sreg >> k;
            // sreg keeps the captured sign bit at the MSB throughout SRA,
            // so an arithmetic shift of the register replicates it.
            2'b10:   shifted = DATA_WIDTH'($signed(sreg) >>> k);
            default: shifted = sreg << k;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            count    <= '0;
            sreg     <= '0;
            op       <= 2'b00;
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE (back-to-back).
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        sreg  <= data_i;
                        count <= shamt_i;
                        op    <= op_i;
                        if (shamt_i == '0) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= data_i;
                        end else begin
                            state  <= SHIFT;
                            busy_o <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                // start_i is ignored here; captured operands stay put.
                SHIFT: begin
                    sreg  <= shifted;
                    count <= count - SHAMT_WIDTH'(k);
                    if (last) begin
                        result_o <= shifted;
                        state    <= DONE;
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle iterative shifter for the MIPS datapath. It executes SLL, SRL and SRA with a 5-bit shift amount.
- It shifts STEP bits per clock under a start/done handshake.
- It complements the fixed right-by-2 byte-to-word address conversion. It provides the left direction and variable-amount shifts for the ALU shift instructions without a full barrel shifter.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width; max shift = 2**SHAMT_WIDTH-1.
- STEP, 1, bits shifted per cycle. Legal values are 1, 2 and 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request pulse; sampled only when the unit is not busy.
- op_i  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 treated as SLL.
- data_i  input  DATA_WIDTH  operand, captured when start is accepted.
- shamt_i  input  SHAMT_WIDTH  shift amount, captured when start is accepted.
- busy_o  output  1  high while state = SHIFT.
- done_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  DATA_WIDTH  shifted result; holds until the next accepted start.

Behaviour:
- One clock domain. Reset is synchronous and active-high, port name reset. Clock port name is clk.
- Reset values:
  - state = IDLE
  - busy_o = 0
  - done_o = 0
  - result_o = 0
  - internal count = 0
  - internal shift register = 0
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When start_i = 1, capture data_i into the shift register, shamt_i into count, and op_i.
  - If shamt_i = 0: go to DONE and set result_o = data_i.
  - Otherwise: go to SHIFT.
- SHIFT:
  - Each cycle shifts by k = min(STEP, count) and sets count -= k.
  - SLL fills zeros at the LSBs. SRL fills zeros at the MSBs. SRA replicates the captured bit DATA_WIDTH-1.
  - When count <= STEP at the start of the cycle, perform the final shift, load result_o with the shifted value, and go to DONE.
  - start_i is ignored in SHIFT; captured operands are not disturbed.
- DONE:
  - done_o = 1 for exactly this cycle. Next state is IDLE.
  - If start_i = 1 in DONE, the request is accepted as if in IDLE, giving back-to-back operation. done_o still pulses once per operation.
- Latency:
  - done_o is high in the cycle following edge number 1 + ceil(shamt/STEP), counting the accepting edge as edge 1.
  - shamt = 0: 1 edge.
  - SLL by 2 with STEP = 1: 3 edges.
  - Maximum with STEP = 1: 32 edges.
- busy_o is asserted exactly while in SHIFT. It is 0 in IDLE and in DONE.
- result_o changes only on entry to DONE and on reset. Intermediate shift-register values are never visible on result_o.
- Width rule: bits shifted past either end are discarded. No carry or overflow output.
- Reset mid-operation: reset wins over all other events. The next cycle is IDLE with all outputs zero, and the in-flight request is lost.
- Simultaneous reset and start_i: reset wins; start is dropped.
- op_i, data_i and shamt_i changing during SHIFT must not affect the result.

Test Plan:
- SLL: data_i = 0x00000001, shamt_i = 2, op_i = 00, STEP = 1.
  - Expect result_o = 0x00000004.
  - done_o high in the cycle after the 3rd edge; busy_o high for 2 cycles.
- SRA: data_i = 0x80000000, shamt_i = 4, op_i = 10.
  - Expect 0xF8000000.
  - Repeat with op_i = 01 (SRL); expect 0x08000000.
- Maximum shift: SRL data_i = 0x80000000, shamt_i = 31.
  - Expect 0x00000001 with done_o after 32 edges.
  - STEP = 4 build: expect the same value after 9 edges.
- Zero shift: shamt_i = 0, data_i = 0xDEADBEEF.
  - done_o in the cycle after the accepting edge; result_o = 0xDEADBEEF; busy_o never asserted.
- Busy collision: start SLL of 0x1 by 8.
  - Mid-SHIFT, pulse start_i with data_i = 0xFFFFFFFF, shamt_i = 1.
  - Expect a single done_o with result_o = 0x00000100.
  - Then a start in the DONE cycle is accepted back-to-back.
- Reset mid-op: start SLL by 20, assert reset at the 5th cycle.
  - Next cycle: busy_o = 0, done_o = 0, result_o = 0, and no done_o pulse follows.
  - A new request then completes normally.
